// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle ARM control FSM with NZCV flags and condition check
// Optional branch-with-link support is enabled by defining CTRL_BL_EN.
module multicycle_ctrl #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ResultSrc,
  output logic        BL,
  output logic [3:0]  State
);

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state;
  logic [3:0] flags;
  logic       cond_ex;
  logic       arith;
  logic       dp_write;
  logic       n, z, c, v;

  // Fields outside the control decode are consumed by the datapath only.
  wire unused_bits = ^{Instr[19:16], Instr[11:0]};

  assign {n, z, c, v} = flags;
  assign arith = ((Instr[24:21] >= 4'd2) && (Instr[24:21] <= 4'd7)) ||
                 (Instr[24:21] == 4'd10) || (Instr[24:21] == 4'd11);
  assign dp_write = cond_ex & (Instr[24:23] != 2'b10);

  always_comb begin
    cond_ex = 1'b0;
    case (Instr[31:28])
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      flags <= FLAG_RESET;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (Instr[27:26])
            2'b01:   state <= MEMADR;
            2'b00:   state <= Instr[25] ? EXECI : EXECR;
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR:  state <= Instr[20] ? MEMREAD : MEMWRITE;
        MEMREAD: state <= MEMWB;
        EXECR, EXECI: begin
          state <= ALUWB;
          // Logical ops leave carry and overflow untouched.
          if (cond_ex && Instr[20]) begin
            flags[3:2] <= ALUFlags[3:2];
            if (arith) flags[1:0] <= ALUFlags[1:0];
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    RegSrc     = 2'b00;
    ImmSrc     = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 4'b0000;
    ResultSrc  = 2'b00;
    BL         = 1'b0;
    if (!reset) begin
      ImmSrc = Instr[27:26];
      case (state)
        FETCH: begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b10;
          ALUControl = ALU_ADD;
          ResultSrc  = 2'b10;
        end
        DECODE: begin
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b10;
          ALUControl = ALU_ADD;
          ResultSrc  = 2'b10;
        end
        MEMADR: begin
          ALUSrcB    = 2'b01;
          ALUControl = Instr[23] ? ALU_ADD : ALU_SUB;
        end
        MEMREAD: AdrSrc = 1'b1;
        MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = cond_ex;
        end
        MEMWRITE: begin
          AdrSrc   = 1'b1;
          RegSrc   = 2'b10;
          MemWrite = cond_ex;
        end
        EXECR: ALUControl = Instr[24:21];
        EXECI: begin
          ALUSrcB    = 2'b01;
          ALUControl = Instr[24:21];
        end
        ALUWB: begin
          RegWrite = dp_write;
          PCWrite  = dp_write & (Instr[15:12] == 4'hF);
        end
        BRANCH: begin
          RegSrc     = 2'b01;
          ALUSrcB    = 2'b01;
          ALUControl = ALU_ADD;
          ResultSrc  = 2'b10;
          PCWrite    = cond_ex;
`ifdef CTRL_BL_EN
          if (Instr[24]) begin
            BL       = 1'b1;
            RegWrite = cond_ex;
          end
`endif
        end
        default: ImmSrc = 2'b00;
      endcase
    end
  end

  assign State = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Instr = 32'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, BL;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0]  ALUControl, State;
  int          n_cmp = 0;
  int          n_bad = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
    .BL(BL), .State(State)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called in FETCH; runs one branch and returns in the next FETCH.
  task automatic run_branch(input string tag, input logic [31:0] ins, input logic exp_pc);
    Instr = ins;
    tick(); check({tag, "_dec"}, State, 1);
    tick(); check({tag, "_st"}, State, 9);
    check({tag, "_pcw"}, PCWrite, exp_pc);
    tick(); check({tag, "_end"}, State, 0);
  endtask

  // Called in FETCH; runs one data-processing instruction to the next FETCH.
  task automatic run_dp(input string tag, input logic [31:0] ins, input logic [3:0] af,
                        input logic [3:0] exp_st, input logic exp_rw, input logic exp_pc);
    Instr = ins; ALUFlags = af;
    tick(); check({tag, "_dec"}, State, 1);
    tick(); check({tag, "_ex"}, State, exp_st);
    check({tag, "_alu"}, ALUControl, ins[24:21]);
    check({tag, "_srcb"}, ALUSrcB, (exp_st == 4'd7) ? 2'b01 : 2'b00);
    tick(); check({tag, "_wb"}, State, 8);
    check({tag, "_rw"}, RegWrite, exp_rw);
    check({tag, "_pcw"}, PCWrite, exp_pc);
    tick(); check({tag, "_end"}, State, 0);
  endtask

  initial begin
    tick(); tick();
    check("rst_state", State, 0);
    check("rst_irw", IRWrite, 0);
    check("rst_pcw", PCWrite, 0);
    reset = 1'b0;
    #1;
    check("fetch_irw", IRWrite, 1);
    check("fetch_pcw", PCWrite, 1);
    check("fetch_srcb", ALUSrcB, 2'b10);
    check("fetch_res", ResultSrc, 2'b10);
    check("fetch_alu", ALUControl, 4'b0100);

    // ADDS R1,R2,#5 then flags 0000 make BEQ untaken
    run_dp("adds", 32'hE2921005, 4'b0000, 4'd7, 1'b1, 1'b0);
    run_branch("beq0", 32'h0A000002, 1'b0);

    // CMP R1,R1 sets Z,C
    run_dp("cmp", 32'hE1510001, 4'b0110, 4'd6, 1'b0, 1'b0);
    run_branch("beq", 32'h0A000002, 1'b1);
    run_branch("bne", 32'h1A000002, 1'b0);
    run_branch("bcs", 32'h2A000000, 1'b1);
    run_branch("bvs0", 32'h6A000000, 1'b0);

    // flags 0011, then ANDS with ALUFlags 1000 gives 1011
    run_dp("cmp2", 32'hE1510001, 4'b0011, 4'd6, 1'b0, 1'b0);
    run_dp("ands", 32'hE0100000, 4'b1000, 4'd6, 1'b1, 1'b0);
    run_branch("bmi", 32'h4A000000, 1'b1);
    run_branch("bvs", 32'h6A000000, 1'b1);
    run_branch("bcs2", 32'h2A000000, 1'b1);
    run_branch("beq2", 32'h0A000000, 1'b0);
    run_branch("bgt", 32'hCA000000, 1'b1);

    // ADD PC and an untaken ADDEQ
    run_dp("addpc", 32'hE281F000, 4'b0000, 4'd7, 1'b1, 1'b1);
    run_dp("addeq", 32'h02811000, 4'b0000, 4'd7, 1'b0, 1'b0);

    // LDR R0,[R1,#-4]
    Instr = 32'hE5110004;
    tick(); check("ldr_dec", State, 1);
    tick(); check("ldr_adr", State, 2);
    check("ldr_alu", ALUControl, 4'b0010);
    check("ldr_srcb", ALUSrcB, 2'b01);
    tick(); check("ldr_rd", State, 3);
    check("ldr_adrsrc", AdrSrc, 1);
    tick(); check("ldr_wb", State, 4);
    check("ldr_res", ResultSrc, 2'b01);
    check("ldr_rw", RegWrite, 1);
    tick(); check("ldr_end", State, 0);

    // STR R0,[R1]
    Instr = 32'hE5810000;
    tick(); check("str_dec", State, 1);
    tick(); check("str_alu", ALUControl, 4'b0100);
    tick(); check("str_st", State, 5);
    check("str_mw", MemWrite, 1);
    check("str_regsrc", RegSrc, 2'b10);
    check("str_adrsrc", AdrSrc, 1);
    tick(); check("str_end", State, 0);

    // BL
    Instr = 32'hEB000010;
    tick(); tick();
    check("bl_st", State, 9);
    check("bl_pcw", PCWrite, 1);
`ifdef CTRL_BL_EN
    check("bl_bl", BL, 1);
    check("bl_rw", RegWrite, 1);
`else
    check("bl_bl", BL, 0);
    check("bl_rw", RegWrite, 0);
`endif
    tick(); check("bl_end", State, 0);

    // undefined class returns straight to FETCH
    Instr = 32'hEC000000;
    tick(); check("undef_dec", State, 1);
    check("undef_rw", RegWrite, 0);
    tick(); check("undef_end", State, 0);

    // reset mid-MEMREAD
    Instr = 32'hE5110004;
    tick(); tick(); tick();
    check("mid_rd", State, 3);
    reset = 1'b1;
    #1;
    check("mid_state", State, 0);
    check("mid_adrsrc", AdrSrc, 0);
    check("mid_irw", IRWrite, 0);
    check("mid_rw", RegWrite, 0);
    tick();
    reset = 1'b0;
    #1;
    check("rel_irw", IRWrite, 1);
    check("rel_pcw", PCWrite, 1);
    run_branch("bmi_rst", 32'h4A000000, 1'b0);
    run_branch("bvc_rst", 32'h7A000000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control unit for the ARM datapath.
- One FSM sequences the shared ALU, register file and memory port over several cycles per instruction.
- Holds the architectural NZCV flags register and evaluates the condition field.
- Decodes data-processing (DP), memory and branch instructions into the datapath's select/strobe signals; the 4-bit ALUControl encoding matches the datapath ALU.

Parameters:
- FLAG_RESET, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- Instr  input  32  instruction register contents (valid from DECODE onward)
- ALUFlags  input  4  NZCV from ALU, current cycle
- PCWrite  output  1  load PC
- IRWrite  output  1  load instruction register
- MemWrite  output  1  data memory write strobe
- RegWrite  output  1  register file write strobe
- AdrSrc  output  1  memory address: 0=PC, 1=ALU result register
- RegSrc  output  2  [0]=RA1 forced to R15, [1]=RA2 from Instr[15:12]
- ImmSrc  output  2  extend mode = Instr[27:26]
- ALUSrcA  output  2  00=RD1, 01=PC
- ALUSrcB  output  2  00=shifted reg, 01=ExtImm, 10=const 4
- ALUControl  output  4  ARM opcode encoding (ADD=0100, SUB=0010)
- ResultSrc  output  2  00=ALUOut reg, 01=ReadData reg, 10=ALUResult direct
- BL  output  1  branch-with-link write (CTRL_BL_EN only)
- State  output  4  current state, for debug

Behaviour:
- Reset (async): state=FETCH, flags=FLAG_RESET, every output 0 while reset is high; takes effect mid-instruction with no completion of the pending write.
- FETCH (0): AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1. Next: DECODE.
- DECODE (1): ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10; no strobes. Next, by Instr[27:26]:
  - 01 -> MEMADR.
  - 00 with Instr[25]=0 -> EXECR.
  - 00 with Instr[25]=1 -> EXECI.
  - 10 -> BRANCH.
  - 11 -> FETCH (undefined; no side effects).
- MEMADR (2): ALUSrcA=00, ALUSrcB=01; ADD if Instr[23]=1, else SUB. Next: MEMREAD if Instr[20]=1, else MEMWRITE.
- MEMREAD (3): AdrSrc=1. Next: MEMWB.
- MEMWB (4): ResultSrc=01, RegWrite=CondEx. Next: FETCH.
- MEMWRITE (5): AdrSrc=1, RegSrc[1]=1, MemWrite=CondEx. Next: FETCH.
- EXECR (6): ALUSrcA=00, ALUSrcB=00, ALUControl=Instr[24:21]. Next: ALUWB.
- EXECI (7): as EXECR but ALUSrcB=01. Next: ALUWB.
- ALUWB (8): ResultSrc=00, RegWrite=CondEx & ~cmp, where cmp = Instr[24:23]==2'b10 (TST/TEQ/CMP/CMN). PCWrite=1 as well if Rd=Instr[15:12]=15 and the write occurs. Next: FETCH.
- BRANCH (9): ALUSrcA=00, RegSrc[0]=1, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx. Next: FETCH.
- Latency per class: branch 3 cycles, DP 4, STR 4, LDR 5.
- Flags update:
  - At the clock edge ending EXECR/EXECI, when CondEx & Instr[20].
  - N,Z always load from ALUFlags.
  - C,V load only for arithmetic opcodes (0010–0111, 1010, 1011).
  - Flags never change in other states.
- CondEx: combinational from Instr[31:28] and the *registered* flags (full ARM EQ..AL table). 4'b1111 treated as never-execute.
- Untaken instruction: same state path and cycle count; strobes suppressed.
- Encodings 10–15 of State are unreachable. If entered, next state is FETCH and all strobes are 0.

Optional Feature:
- Macro: CTRL_BL_EN.
- Defined: in BRANCH with Instr[24]=1, BL=1 and RegWrite=CondEx in the same cycle as PCWrite. The datapath then writes the return address to R14.
- Undefined: BL tied 0, Instr[24] ignored, BL and B behave identically.

Test Plan:
- Reset asserted mid-MEMREAD -> State=0, all strobes 0, flags=0000 immediately. After release: one FETCH cycle with IRWrite=PCWrite=1.
- ADDS R1,R2,#5 (E2921005), ALUFlags=0000 -> states 0,1,7,8; ALUControl=0100 in EXECI; RegWrite=1 in ALUWB; flags=0000.
- CMP R1,R1 (E1510001), ALUFlags=0110 -> flags=0110, no RegWrite. Then BEQ (0A000002) -> PCWrite=1 in BRANCH. Then BNE (1A000002) -> PCWrite=0, still 3 cycles.
- LDR R0,[R1,#-4] (E5110004) -> MEMADR ALUControl=0010; MEMREAD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1; 5 cycles total.
- ANDS with C,V flags set and ALUFlags=1000 -> N=1, Z=0, C and V retained.
- BL (EB000010) with CTRL_BL_EN -> BL=1, RegWrite=1, PCWrite=1 in BRANCH. Without the macro -> BL=0, RegWrite=0.
